// File: rtl/uart_cmd_parser_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : uart_cmd_parser_pkg                                        |
// | Brief   : Shared sync marker, ACK status codes and parser states.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package uart_cmd_parser_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    localparam logic [7:0] ST_OK   = 8'h00;
    localparam logic [7:0] ST_CSUM = 8'h01;
    localparam logic [7:0] ST_LEN  = 8'h02;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_OPCODE  = 3'd1,
        S_LEN     = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CHECK   = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/uart_cmd_parser_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : uart_cmd_parser_if                                         |
// | Brief   : Byte stream in, packet/error/ACK signals out.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface uart_cmd_parser_if #(
    parameter int DBITS       = 8,
    parameter int MAX_PAYLOAD = 4,
    parameter int LEN_BITS    = 3
);
    logic                         rx_valid;
    logic [DBITS-1:0]             rx_byte;
    logic                         pkt_valid;
    logic [DBITS-1:0]             pkt_opcode;
    logic [LEN_BITS-1:0]          pkt_len;
    logic [DBITS*MAX_PAYLOAD-1:0] pkt_payload;
    logic                         err_checksum;
    logic                         err_length;
    logic                         err_timeout;
    logic                         busy;
    logic                         tx_trigger;
    logic [4*DBITS-1:0]           tx_in;

    modport master (
        input  rx_valid, rx_byte,
        output pkt_valid, pkt_opcode, pkt_len, pkt_payload,
        output err_checksum, err_length, err_timeout, busy,
        output tx_trigger, tx_in
    );

    modport slave (
        output rx_valid, rx_byte,
        input  pkt_valid, pkt_opcode, pkt_len, pkt_payload,
        input  err_checksum, err_length, err_timeout, busy,
        input  tx_trigger, tx_in
    );
endinterface
`default_nettype wire

// File: rtl/uart_byte_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : uart_byte_timer                                            |
// | Brief   : Inter-byte watchdog; one-cycle expire strobe.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_byte_timer #(
    parameter int TIMEOUT_CYC = 1000000,
    parameter int TO_BITS     = 20
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clear,
    input  wire logic i_enable,
    output logic      o_expire
);
    // cnt_q is 0 in the first cycle after a byte; the parser registers the
    // strobe one cycle after expire, so the error lands TIMEOUT_CYC-1 cycles
    // after the byte cycle.
    localparam logic [TO_BITS-1:0] LIMIT = TO_BITS'(TIMEOUT_CYC - 3);

    logic [TO_BITS-1:0] cnt_q;
    logic [TO_BITS-1:0] cnt_d;

    assign o_expire = i_enable && !i_clear && (cnt_q == LIMIT);

    always_comb begin
        cnt_d = cnt_q + TO_BITS'(1);
        if (i_clear || !i_enable || o_expire) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : uart_cmd_parser                                            |
// | Brief   : Frames UART bytes into checksummed packets, builds ACKs.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_cmd_parser
    import uart_cmd_parser_pkg::*;
#(
    parameter int               DBITS       = 8,
    parameter int               MAX_PAYLOAD = 4,
    parameter int               LEN_BITS    = 3,
    parameter logic [DBITS-1:0] SYNC_BYTE   = DBITS'(SYNC_BYTE_DEF),
    parameter int               TIMEOUT_CYC = 1000000,
    parameter int               TO_BITS     = 20
) (
    input  wire logic         clk_100MHz,
    input  wire logic         reset,
    uart_cmd_parser_if.master bus
);
    localparam int PBITS = DBITS * MAX_PAYLOAD;

    state_e              state_q, state_d;
    logic [DBITS-1:0]    opc_q, opc_d, sum_q, sum_d;
    logic [LEN_BITS-1:0] len_q, len_d, idx_q, idx_d;
    logic [PBITS-1:0]    buf_q, buf_d;
    logic                busy_q, busy_d;
    logic                pkt_valid_q, pkt_valid_d;
    logic                err_checksum_q, err_checksum_d;
    logic                err_length_q, err_length_d;
    logic                err_timeout_q, err_timeout_d;
    logic                tx_trigger_q, tx_trigger_d;
    logic [DBITS-1:0]    pkt_opcode_q, pkt_opcode_d;
    logic [LEN_BITS-1:0] pkt_len_q, pkt_len_d;
    logic [PBITS-1:0]    pkt_payload_q, pkt_payload_d;
    logic [4*DBITS-1:0]  tx_in_q, tx_in_d;

    logic                w_expire;
    logic [DBITS-1:0]    w_sum_next;
    logic [LEN_BITS-1:0] w_idx_next;

    uart_byte_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_BITS     (TO_BITS)
    ) u_timer (
        .clk      (clk_100MHz),
        .rst      (reset),
        .i_clear  (bus.rx_valid),
        .i_enable (state_q != S_IDLE),
        .o_expire (w_expire)
    );

    function automatic logic [4*DBITS-1:0] ack_word(input logic [DBITS-1:0] opc,
                                                    input logic [DBITS-1:0] st);
        return {SYNC_BYTE, opc, st, opc + st};
    endfunction

    assign w_sum_next = sum_q + bus.rx_byte;
    assign w_idx_next = idx_q + LEN_BITS'(1);

    always_comb begin
        state_d        = state_q;
        opc_d          = opc_q;
        sum_d          = sum_q;
        len_d          = len_q;
        idx_d          = idx_q;
        buf_d          = buf_q;
        pkt_valid_d    = 1'b0;
        err_checksum_d = 1'b0;
        err_length_d   = 1'b0;
        err_timeout_d  = 1'b0;
        tx_trigger_d   = 1'b0;
        pkt_opcode_d   = pkt_opcode_q;
        pkt_len_d      = pkt_len_q;
        pkt_payload_d  = pkt_payload_q;
        tx_in_d        = tx_in_q;

        // Expire is already gated off by a same-cycle byte, so the byte wins.
        if (w_expire) begin
            err_timeout_d = 1'b1;
            state_d       = S_IDLE;
        end else if (bus.rx_valid) begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.rx_byte == SYNC_BYTE) begin
                        buf_d   = '0;
                        idx_d   = '0;
                        sum_d   = '0;
                        state_d = S_OPCODE;
                    end
                end
                S_OPCODE: begin
                    opc_d   = bus.rx_byte;
                    sum_d   = bus.rx_byte;
                    state_d = S_LEN;
                end
                S_LEN: begin
                    sum_d = w_sum_next;
                    if (bus.rx_byte > DBITS'(MAX_PAYLOAD)) begin
                        err_length_d = 1'b1;
                        tx_trigger_d = 1'b1;
                        tx_in_d      = ack_word(opc_q, DBITS'(ST_LEN));
                        state_d      = S_IDLE;
                    end else begin
                        len_d   = LEN_BITS'(bus.rx_byte);
                        state_d = (bus.rx_byte == '0) ? S_CHECK : S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    for (int i = 0; i < MAX_PAYLOAD; i++) begin
                        if (idx_q == LEN_BITS'(i)) begin
                            buf_d[i*DBITS +: DBITS] = bus.rx_byte;
                        end
                    end
                    sum_d = w_sum_next;
                    idx_d = w_idx_next;
                    if (w_idx_next == len_q) begin
                        state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    tx_trigger_d = 1'b1;
                    if (bus.rx_byte == sum_q) begin
                        pkt_valid_d   = 1'b1;
                        pkt_opcode_d  = opc_q;
                        pkt_len_d     = len_q;
                        pkt_payload_d = buf_q;
                        tx_in_d       = ack_word(opc_q, DBITS'(ST_OK));
                    end else begin
                        err_checksum_d = 1'b1;
                        tx_in_d        = ack_word(opc_q, DBITS'(ST_CSUM));
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q        <= S_IDLE;
            opc_q          <= '0;
            sum_q          <= '0;
            len_q          <= '0;
            idx_q          <= '0;
            buf_q          <= '0;
            busy_q         <= 1'b0;
            pkt_valid_q    <= 1'b0;
            err_checksum_q <= 1'b0;
            err_length_q   <= 1'b0;
            err_timeout_q  <= 1'b0;
            tx_trigger_q   <= 1'b0;
            pkt_opcode_q   <= '0;
            pkt_len_q      <= '0;
            pkt_payload_q  <= '0;
            tx_in_q        <= '0;
        end else begin
            state_q        <= state_d;
            opc_q          <= opc_d;
            sum_q          <= sum_d;
            len_q          <= len_d;
            idx_q          <= idx_d;
            buf_q          <= buf_d;
            busy_q         <= busy_d;
            pkt_valid_q    <= pkt_valid_d;
            err_checksum_q <= err_checksum_d;
            err_length_q   <= err_length_d;
            err_timeout_q  <= err_timeout_d;
            tx_trigger_q   <= tx_trigger_d;
            pkt_opcode_q   <= pkt_opcode_d;
            pkt_len_q      <= pkt_len_d;
            pkt_payload_q  <= pkt_payload_d;
            tx_in_q        <= tx_in_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.pkt_valid    = pkt_valid_q;
    assign bus.err_checksum = err_checksum_q;
    assign bus.err_length   = err_length_q;
    assign bus.err_timeout  = err_timeout_q;
    assign bus.tx_trigger   = tx_trigger_q;
    assign bus.pkt_opcode   = pkt_opcode_q;
    assign bus.pkt_len      = pkt_len_q;
    assign bus.pkt_payload  = pkt_payload_q;
    assign bus.tx_in        = tx_in_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_uart_cmd_parser                                         |
// | Brief   : Directed + random packets against a queue-based model.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_uart_cmd_parser;
    localparam int DBITS       = 8;
    localparam int MAX_PAYLOAD = 4;
    localparam int LEN_BITS    = 3;
    localparam int TIMEOUT_CYC = 100;
    localparam int TO_BITS     = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_cmd_parser_if #(.DBITS(DBITS), .MAX_PAYLOAD(MAX_PAYLOAD), .LEN_BITS(LEN_BITS)) bus ();

    uart_cmd_parser #(
        .DBITS       (DBITS),
        .MAX_PAYLOAD (MAX_PAYLOAD),
        .LEN_BITS    (LEN_BITS),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_BITS     (TO_BITS)
    ) dut (
        .clk_100MHz (clk),
        .reset      (rst),
        .bus        (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: bytes after SYNC collected in a queue, decided by size.
    bit         m_in_pkt = 1'b0;
    logic [7:0] m_q[$];
    int         m_gap    = 0;
    logic [4:0] e_strb;            // {pkt_valid, err_checksum, err_length, err_timeout, tx_trigger}
    logic [7:0] e_opc    = '0;
    logic [2:0] e_plen   = '0;
    logic [31:0] e_pay   = '0;
    logic [31:0] e_tx    = '0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_ack(input logic [7:0] opc, input logic [7:0] st);
        logic [7:0] s;
        s         = opc + st;
        e_strb[0] = 1'b1;
        e_tx      = {8'hA5, opc, st, s};
    endtask

    task automatic model_byte(input logic [7:0] b);
        int         n;
        logic [7:0] s;
        if (!m_in_pkt) begin
            if (b == 8'hA5) begin
                m_in_pkt = 1'b1;
                m_q.delete();
            end
        end else begin
            m_q.push_back(b);
            n = m_q.size();
            if (n == 2 && int'(m_q[1]) > MAX_PAYLOAD) begin
                e_strb[2] = 1'b1;
                model_ack(m_q[0], 8'h02);
                m_in_pkt = 1'b0;
            end else if (n >= 2 && n == int'(m_q[1]) + 3) begin
                s = 8'h00;
                for (int i = 0; i < n - 1; i++) s = s + m_q[i];
                if (m_q[n-1] == s) begin
                    e_strb[4] = 1'b1;
                    e_opc     = m_q[0];
                    e_plen    = m_q[1][2:0];
                    e_pay     = '0;
                    for (int i = 0; i < int'(m_q[1]); i++) e_pay[8*i +: 8] = m_q[2+i];
                    model_ack(m_q[0], 8'h00);
                end else begin
                    e_strb[3] = 1'b1;
                    model_ack(m_q[0], 8'h01);
                end
                m_in_pkt = 1'b0;
            end
        end
    endtask

    // Entered at a falling edge: drive one cycle, then check the next cycle.
    task automatic tick(input bit v, input logic [7:0] b);
        bus.rx_valid = v;
        bus.rx_byte  = v ? b : 8'($urandom);
        e_strb       = '0;
        if (rst) begin
            m_in_pkt = 1'b0;
            e_opc = '0; e_plen = '0; e_pay = '0; e_tx = '0;
        end else if (v) begin
            model_byte(b);
            m_gap = 1;
        end else if (m_in_pkt) begin
            m_gap++;
            if (m_gap == TIMEOUT_CYC - 1) begin
                e_strb[1] = 1'b1;
                m_in_pkt  = 1'b0;
            end
        end
        @(negedge clk);
        check_val("strobes", {bus.pkt_valid, bus.err_checksum, bus.err_length,
                              bus.err_timeout, bus.tx_trigger}, e_strb);
        check_val("busy", bus.busy, m_in_pkt);
        check_val("pkt_opcode", bus.pkt_opcode, e_opc);
        check_val("pkt_len", bus.pkt_len, e_plen);
        check_val("pkt_payload", bus.pkt_payload, e_pay);
        check_val("tx_in", bus.tx_in, e_tx);
    endtask

    task automatic send_seq(input logic [7:0] s[$]);
        foreach (s[i]) tick(1'b1, s[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] seq[$];
        int         n;
        bus.rx_valid = 1'b0;
        bus.rx_byte  = '0;
        rst = 1'b1;
        @(negedge clk);
        idle(3);
        check_val("reset_tx_in", bus.tx_in, 32'h0);
        rst = 1'b0;
        idle(2);

        // Good packet
        seq = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h45};
        send_seq(seq);
        check_val("s1_pkt_valid", bus.pkt_valid, 1'b1);
        check_val("s1_payload", bus.pkt_payload, 32'h00002211);
        check_val("s1_tx_in", bus.tx_in, 32'hA5100010);
        idle(2);

        // Bad checksum keeps previous packet
        seq = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h46};
        send_seq(seq);
        check_val("s2_err_checksum", bus.err_checksum, 1'b1);
        check_val("s2_tx_in", bus.tx_in, 32'hA5100111);
        check_val("s2_payload_held", bus.pkt_payload, 32'h00002211);
        idle(2);

        // Length error, then zero-length packet
        seq = '{8'hA5, 8'h20, 8'h05};
        send_seq(seq);
        check_val("s3_err_length", bus.err_length, 1'b1);
        check_val("s3_tx_in", bus.tx_in, 32'hA5200222);
        idle(1);
        seq = '{8'hA5, 8'h33, 8'h00, 8'h33};
        send_seq(seq);
        check_val("s3_len0_valid", bus.pkt_valid, 1'b1);
        check_val("s3_len0_payload", bus.pkt_payload, 32'h0);
        idle(2);

        // Timeout latency, counted from the cycle that carried the byte
        seq = '{8'hA5, 8'h10};
        send_seq(seq);
        n = 1;
        while (!bus.err_timeout && n < 200) begin
            tick(1'b0, 8'h00);
            n++;
        end
        check_val("s4_timeout_cycles", n, TIMEOUT_CYC - 1);
        check_val("s4_busy_dropped", bus.busy, 1'b0);
        idle(2);

        // Byte landing on the would-be timeout cycle is taken instead
        seq = '{8'hA5, 8'h10};
        send_seq(seq);
        idle(TIMEOUT_CYC - 3);
        seq = '{8'h02, 8'h11, 8'h22, 8'h45};
        send_seq(seq);
        check_val("s4_late_byte_valid", bus.pkt_valid, 1'b1);
        idle(2);

        // Noise before sync, SYNC value inside payload; 44+01+A5 = EA
        seq = '{8'h00, 8'hFF, 8'hA5, 8'h44, 8'h01, 8'hA5, 8'hEA};
        send_seq(seq);
        check_val("s5_pkt_valid", bus.pkt_valid, 1'b1);
        check_val("s5_payload", bus.pkt_payload, 32'h000000A5);
        idle(2);

        // Reset mid-packet
        seq = '{8'hA5, 8'h10, 8'h02, 8'h11};
        send_seq(seq);
        rst = 1'b1;
        idle(2);
        check_val("s6_reset_payload", bus.pkt_payload, 32'h0);
        rst = 1'b0;
        idle(1);
        seq = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h45};
        send_seq(seq);
        check_val("s6_tx_in", bus.tx_in, 32'hA5100010);
        idle(2);

        // Random packets with random gaps (including back-to-back bytes)
        for (int p = 0; p < 80; p++) begin
            logic [7:0] opc, len, sum, b;
            logic [7:0] pk[$];
            int         cut;
            pk.delete();
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                do b = 8'($urandom); while (b == 8'hA5);
                pk.push_back(b);
            end
            opc = 8'($urandom);
            len = ($urandom_range(0, 6) == 0) ? 8'($urandom_range(5, 255)) : 8'($urandom_range(0, 4));
            pk.push_back(8'hA5);
            pk.push_back(opc);
            pk.push_back(len);
            sum = opc + len;
            if (len <= 8'(MAX_PAYLOAD)) begin
                for (int k = 0; k < int'(len); k++) begin
                    b = ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom);
                    pk.push_back(b);
                    sum = sum + b;
                end
                if ($urandom_range(0, 3) == 0) sum = sum ^ 8'($urandom_range(1, 255));
                pk.push_back(sum);
            end
            cut = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, pk.size() - 1)) : pk.size();
            for (int k = 0; k < cut; k++) begin
                tick(1'b1, pk[k]);
                idle(int'($urandom_range(0, 2)));
            end
            for (int k = 0; k < 200 && m_in_pkt; k++) tick(1'b0, 8'h00);
            idle(int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
